// File: rtl/load_unit.sv
// RV32I load unit: issues a word-aligned data memory read, waits for the response,
// then returns the byte/halfword/word extracted and extended for the register file.
module load_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] load_address,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd_index,
  output logic        busy,
  output logic        mem_read_request,
  output logic [31:0] mem_address,
  input  logic        mem_ready,
  input  logic        mem_read_valid,
  input  logic [31:0] mem_read_data,
  output logic        result_valid,
  output logic [31:0] result_value,
  output logic [4:0]  result_rd,
  output logic        fault,
  output logic [1:0]  fault_code
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQUEST = 3'd1,
    S_WAIT    = 3'd2,
    S_DONE    = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t      state_r;
  logic [1:0]  offset_r;
  logic [2:0]  funct3_r;
  logic [4:0]  rd_r;
  logic [7:0]  timer_r;

  function automatic logic funct3_illegal(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: funct3_illegal = 1'b0;
      default:                                funct3_illegal = 1'b1;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] offset);
    case (f3)
      3'b001, 3'b101: misaligned = offset[0];
      3'b010:         misaligned = (offset != 2'b00);
      default:        misaligned = 1'b0;
    endcase
  endfunction

  // Selects the addressed lane of a little-endian word and extends it to 32 bits.
  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] offset,
                                          input logic [2:0] f3);
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    case (offset)
      2'd0:    lane_byte = word[7:0];
      2'd1:    lane_byte = word[15:8];
      2'd2:    lane_byte = word[23:16];
      2'd3:    lane_byte = word[31:24];
      default: lane_byte = 8'd0;
    endcase
    lane_half = offset[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  extract = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  extract = {{16{lane_half[15]}}, lane_half};
      3'b010:  extract = word;
      3'b100:  extract = {24'd0, lane_byte};
      3'b101:  extract = {16'd0, lane_half};
      default: extract = 32'd0;
    endcase
  endfunction

  // Load sequencer; every output is a register updated alongside the state.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r          <= S_IDLE;
      offset_r         <= 2'd0;
      funct3_r         <= 3'd0;
      rd_r             <= 5'd0;
      timer_r          <= 8'd0;
      busy             <= 1'b0;
      mem_read_request <= 1'b0;
      mem_address      <= 32'd0;
      result_valid     <= 1'b0;
      result_value     <= 32'd0;
      result_rd        <= 5'd0;
      fault            <= 1'b0;
      fault_code       <= 2'b00;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (enable) begin
            offset_r <= load_address[1:0];
            funct3_r <= funct3;
            rd_r     <= rd_index;
            timer_r  <= 8'd0;
            busy     <= 1'b1;
            if (funct3_illegal(funct3)) begin
              state_r    <= S_FAULT;
              fault      <= 1'b1;
              fault_code <= 2'b10;
            end else if (misaligned(funct3, load_address[1:0])) begin
              state_r    <= S_FAULT;
              fault      <= 1'b1;
              fault_code <= 2'b01;
            end else begin
              state_r          <= S_REQUEST;
              mem_read_request <= 1'b1;
              mem_address      <= {load_address[31:2], 2'b00};
            end
          end else begin
            busy <= 1'b0;
          end
        end
        S_REQUEST: begin
          // Timeout is checked first so it wins over a same-cycle handshake.
          if (timer_r + 8'd1 == TIMEOUT_LIMIT) begin
            state_r          <= S_FAULT;
            mem_read_request <= 1'b0;
            fault            <= 1'b1;
            fault_code       <= 2'b11;
          end else begin
            timer_r <= timer_r + 8'd1;
            if (mem_ready) begin
              state_r          <= S_WAIT;
              mem_read_request <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          if (timer_r + 8'd1 == TIMEOUT_LIMIT) begin
            state_r    <= S_FAULT;
            fault      <= 1'b1;
            fault_code <= 2'b11;
          end else begin
            timer_r <= timer_r + 8'd1;
            if (mem_read_valid) begin
              state_r      <= S_DONE;
              result_valid <= 1'b1;
              result_value <= extract(mem_read_data, offset_r, funct3_r);
              result_rd    <= rd_r;
            end
          end
        end
        S_DONE: begin
          state_r      <= S_IDLE;
          result_valid <= 1'b0;
          busy         <= 1'b0;
        end
        S_FAULT: begin
          state_r    <= S_IDLE;
          fault      <= 1'b0;
          fault_code <= 2'b00;
          busy       <= 1'b0;
        end
        default: begin
          state_r          <= S_IDLE;
          busy             <= 1'b0;
          mem_read_request <= 1'b0;
          result_valid     <= 1'b0;
          fault            <= 1'b0;
          fault_code       <= 2'b00;
        end
      endcase
    end
  end

endmodule
